// File: rtl/if_queue.sv
// Instruction-fetch queue: issues in-order imem requests for the PC stage, buffers
// PC-tagged responses in a small FIFO for decode, and drops everything in flight on a taken branch.
module if_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic                   pc_valid_i,
  output logic                   pc_ready_o,
  input  logic                   flush_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [DATA_WIDTH-1:0]  instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t                instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] tag_mem   [DEPTH];

  logic [PW-1:0] iwr_q, iwr_d, ird_q, ird_d;
  logic [PW-1:0] twr_q, twr_d, trd_q, trd_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;

  logic [CW:0] load;
  logic        credit, req_acc, rsp_take, rsp_drop, pop;
  entry_t      head;

  // Responses still owed to discarded requests occupy credit just like live ones.
  assign load     = (CW+1)'(count_q) + (CW+1)'(outst_q) + (CW+1)'(discard_q);
  assign credit   = load < (CW+1)'(DEPTH);

  assign imem_req_o  = rst & pc_valid_i & credit & ~flush_i;
  assign imem_addr_o = {pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign req_acc     = imem_req_o & imem_gnt_i;
  assign pc_ready_o  = req_acc;

  assign rsp_drop = imem_rvalid_i & (discard_q != '0);
  assign rsp_take = imem_rvalid_i & (discard_q == '0) & (outst_q != '0);

  assign head          = instr_mem[ird_q];
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? head.instr : NOP;
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;
  assign count_o       = count_q;
  assign pop           = instr_valid_o & instr_ready_i;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    iwr_d     = iwr_q;
    ird_d     = ird_q;
    twr_d     = twr_q;
    trd_d     = trd_q;
    count_d   = count_q + CW'(rsp_take) - CW'(pop);
    outst_d   = outst_q + CW'(req_acc) - CW'(rsp_take);
    discard_d = discard_q - CW'(rsp_drop);

    if (req_acc)  twr_d = twr_q + 1'b1;
    if (rsp_take) begin
      trd_d = trd_q + 1'b1;
      iwr_d = iwr_q + 1'b1;
    end
    if (pop)      ird_d = ird_q + 1'b1;

    if (flush_i) begin
      iwr_d     = '0;
      ird_d     = '0;
      twr_d     = '0;
      trd_d     = '0;
      count_d   = '0;
      outst_d   = '0;
      // Every request still in flight turns into a response to be dropped.
      discard_d = outst_q - CW'(rsp_take) + discard_q - CW'(rsp_drop);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iwr_q     <= '0;
      ird_q     <= '0;
      twr_q     <= '0;
      trd_q     <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      iwr_q     <= iwr_d;
      ird_q     <= ird_d;
      twr_q     <= twr_d;
      trd_q     <= trd_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  // NOTE: storage arrays are not reset; the counters alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (req_acc) tag_mem[twr_q] <= pc_i;
    if (rsp_take && !flush_i) instr_mem[iwr_q] <= {imem_rdata_i, tag_mem[trd_q]};
  end

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid_i |-> (outst_q != '0 || discard_q != '0));
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_take && !pop && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && count_q == '0));
`endif

endmodule

// File: tb/tb_if_queue.sv
// Bench for if_queue: directed fetch sequences against a one-cycle-latency memory model,
// with a scoreboard of expected {instr, pc} pairs checked by an independent decode monitor.
module tb_if_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i, pc_ready_o, flush_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] instr_o, instr_pc_o;
  logic [2:0]  count_o;

  if_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pend[$];
  bit          mem_en;
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_instr(input logic [31:0] addr, input logic [31:0] pc);
    sb.push_back({mem_data(addr), pc});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || pend.size() != 0 || count_o != 3'd0) && n < budget) begin
      next();
      n++;
    end
    mid();
    check({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    check({name, "_count_zero"}, 64'(count_o), 64'd0);
    next();
  endtask

  // Memory model: answers every granted address in order, one cycle after grant.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && mem_en && pend.size() > 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_data(pend[0]);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        imem_rvalid_i = 1'b0;
      end else begin
        if (imem_rvalid_i) void'(pend.pop_front());
        if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
      end
    end
  end

  // Decode-side monitor: every consumed head must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst && instr_valid_o && instr_ready_i) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_instr: got pc %0h instr %0h, none expected", instr_pc_o, instr_o);
      end else begin
        e = sb.pop_front();
        check("instr_head", {instr_o, instr_pc_o}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pc_i = 32'h0; pc_valid_i = 1'b1; flush_i = 1'b0;
    imem_gnt_i = 1'b1; instr_ready_i = 1'b0; mem_en = 1'b1;

    // Reset state, with a request pending on the inputs.
    #12;
    check("rst_instr_valid", 64'(instr_valid_o), 64'd0);
    check("rst_pc_ready",    64'(pc_ready_o),    64'd0);
    check("rst_imem_req",    64'(imem_req_o),    64'd0);
    check("rst_count",       64'(count_o),       64'd0);
    check("rst_instr_nop",   64'(instr_o),       64'(NOP));
    check("rst_instr_pc",    64'(instr_pc_o),    64'd0);
    pc_valid_i = 1'b0;
    mid();
    rst = 1'b1;
    next();

    // Streaming fetch with decode always ready.
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'(i * 4); pc_valid_i = 1'b1;
      expect_instr(pc_i, pc_i);
      mid();
      check("t1_pc_ready", 64'(pc_ready_o), 64'd1);
      check("t1_count_le1", 64'(count_o <= 3'd1), 64'd1);
      next();
    end
    pc_valid_i = 1'b0;
    drain("t1", 20);

    // Decode stalled: only DEPTH of six requests are accepted.
    instr_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc_i = 32'(i * 4); pc_valid_i = 1'b1;
      if (i < 4) expect_instr(pc_i, pc_i);
      mid();
      check("t2_pc_ready", 64'(pc_ready_o), (i < 4) ? 64'd1 : 64'd0);
      next();
    end
    mid();
    check("t2_full_count", 64'(count_o),    64'd4);
    check("t2_full_req",   64'(imem_req_o), 64'd0);
    next();
    pc_valid_i = 1'b0; instr_ready_i = 1'b1;
    drain("t2", 20);

    // Flush with two requests in flight; their responses must be dropped.
    mem_en = 1'b0;
    pc_i = 32'h10; pc_valid_i = 1'b1;
    mid(); check("t3_acc_10", 64'(pc_ready_o), 64'd1); next();
    pc_i = 32'h14;
    mid(); check("t3_acc_14", 64'(pc_ready_o), 64'd1); next();
    pc_i = 32'h30; flush_i = 1'b1;
    mid();
    check("t3_flush_no_req",   64'(imem_req_o), 64'd0);
    check("t3_flush_no_ready", 64'(pc_ready_o), 64'd0);
    next();
    flush_i = 1'b0; pc_i = 32'h40;
    expect_instr(32'h40, 32'h40);
    mid(); check("t3_acc_40", 64'(pc_ready_o), 64'd1); next();
    pc_valid_i = 1'b0; mem_en = 1'b1;
    drain("t3", 20);

    // Flush coinciding with a response and a pop at count=2.
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h20 + 32'(i * 4); pc_valid_i = 1'b1;
      mid(); check("t4_acc", 64'(pc_ready_o), 64'd1); next();
    end
    pc_valid_i = 1'b0; flush_i = 1'b1; instr_ready_i = 1'b1;
    expect_instr(32'h20, 32'h20);
    mid(); check("t4_pre_count", 64'(count_o), 64'd2); next();
    flush_i = 1'b0;
    mid();
    check("t4_post_count", 64'(count_o),       64'd0);
    check("t4_post_valid", 64'(instr_valid_o), 64'd0);
    next();
    pc_i = 32'h50; pc_valid_i = 1'b1;
    expect_instr(32'h50, 32'h50);
    mid(); check("t4_acc_50", 64'(pc_ready_o), 64'd1); next();
    pc_valid_i = 1'b0;
    drain("t4", 20);

    // Grant withheld for three cycles; unaligned PC is word-aligned on the bus.
    imem_gnt_i = 1'b0; pc_i = 32'h1003; pc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t5_req_held",  64'(imem_req_o),  64'd1);
      check("t5_no_ready",  64'(pc_ready_o),  64'd0);
      check("t5_addr_align", 64'(imem_addr_o), 64'h1000);
      next();
    end
    imem_gnt_i = 1'b1;
    expect_instr(32'h1000, 32'h1003);
    mid(); check("t5_acc", 64'(pc_ready_o), 64'd1); next();
    pc_valid_i = 1'b0;
    drain("t5", 20);

    // Asynchronous reset with three instructions buffered.
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h60 + 32'(i * 4); pc_valid_i = 1'b1;
      mid(); check("t6_acc", 64'(pc_ready_o), 64'd1); next();
    end
    pc_valid_i = 1'b0;
    next();
    #2;
    check("t6_pre_count", 64'(count_o), 64'd3);
    rst = 1'b0;
    #1;
    check("t6_async_valid", 64'(instr_valid_o), 64'd0);
    check("t6_async_nop",   64'(instr_o),       64'(NOP));
    check("t6_async_pc",    64'(instr_pc_o),    64'd0);
    check("t6_async_count", 64'(count_o),       64'd0);
    mid();
    next();
    rst = 1'b1;
    next();
    instr_ready_i = 1'b1; pc_i = 32'h70; pc_valid_i = 1'b1;
    expect_instr(32'h70, 32'h70);
    mid(); check("t6_acc_70", 64'(pc_ready_o), 64'd1); next();
    pc_valid_i = 1'b0;
    drain("t6", 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_queue.md
Name: if_queue

Overview:
- Instruction-fetch stage directly downstream of the PC stage.
- Takes the current fetch address (`PC`) each cycle and issues in-order requests to instruction memory.
- Buffers returned instructions, tagged with their PC, in a small FIFO and hands them to decode over a valid/ready handshake.
- Flushes everything in flight when a branch is taken (`PCSrc`).

Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, ≥2); also the maximum outstanding requests.
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, instruction width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pc_i  input  ADDR_WIDTH  fetch address from PC stage.
- pc_valid_i  input  1  pc_i is a fetch request.
- pc_ready_o  output  1  request accepted this cycle (PC stage may advance).
- flush_i  input  1  branch taken (PCSrc); discard all buffered and in-flight instructions.
- imem_req_o  output  1  memory request.
- imem_addr_o  output  ADDR_WIDTH  word-aligned request address.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  response data valid (in order, ≥1 cycle after grant).
- imem_rdata_i  input  DATA_WIDTH  response instruction.
- instr_valid_o  output  1  head of FIFO valid.
- instr_o  output  DATA_WIDTH  head instruction.
- instr_pc_o  output  ADDR_WIDTH  PC of head instruction.
- instr_ready_i  input  1  decode consumes head this cycle.
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO pointers, count, outstanding and discard counters cleared.
  - instr_valid_o=0, pc_ready_o=0, imem_req_o=0, count_o=0.
  - instr_o=32'h00000013 (NOP), instr_pc_o=0.
- Credit: credit = (count + outstanding) < DEPTH, computed from registered values only.
- Request issue:
  - imem_req_o = pc_valid_i & credit & ~flush_i.
  - imem_addr_o = {pc_i[ADDR_WIDTH-1:2], 2'b00}, combinational.
  - pc_ready_o = imem_req_o & imem_gnt_i.
  - On accept, push pc_i into an internal DEPTH-entry tag FIFO and increment outstanding.
- Response (imem_rvalid_i=1):
  - If the discard counter is >0: decrement it and drop the data.
  - Otherwise: pop the tag FIFO, write {rdata, tag} into the instruction FIFO, count+1, outstanding−1.
  - A response never arrives with outstanding=0 and discard=0. If it does, it is ignored; assertion only in simulation.
- Output:
  - instr_valid_o = (count≠0).
  - instr_o / instr_pc_o come from the head entry, zero added latency.
  - When count=0, instr_o=NOP and instr_pc_o=0.
  - Pop on instr_valid_o & instr_ready_i.
- Latency: grant at cycle N, rvalid at cycle N+k → instruction visible at decode in cycle N+k+1.
- Simultaneous push and pop: count unchanged; allowed at any occupancy, including full.
- Full: credit=0 → no request, pc_ready_o=0. Not reachable with count=DEPTH and a pending response, by construction of the credit rule.
- Flush (flush_i=1), registered effect at the next edge:
  - Instruction FIFO and tag FIFO emptied.
  - discard ← outstanding − (rvalid this cycle & discard==0 ? 1 : 0) + discard − (rvalid & discard>0 ? 1 : 0).
  - outstanding ← 0.
  - No request is issued in the flush cycle; a pop in that cycle is still honoured for decode.
  - Issue resumes the next cycle even while discard>0. New responses are consumed only after the discard count reaches 0, and credit counts discard as outstanding.
- Pointers wrap modulo DEPTH. count saturates neither way; overflow/underflow is a design error, covered by assertions.
- Reset mid-transaction: all state cleared immediately. Memory responses after reset release are the memory's responsibility (memory is reset with the same signal).

Test Plan:
- Reset, then pc_i=0,4,8,… with gnt=1 and rvalid one cycle later, instr_ready_i=1 → one instruction per cycle; instr_pc_o=0,4,8; count_o≤1.
- instr_ready_i=0, DEPTH=4, 6 fetch requests → exactly 4 accepted; pc_ready_o=0 afterwards; count_o=4; release ready → pops in order 0,4,8,12.
- Two requests outstanding (pc 0x10, 0x14), flush_i pulse, then pc 0x40 → responses for 0x10/0x14 discarded; first instr_pc_o=0x40 with its rdata.
- Flush in the same cycle as rvalid and pop with count=2 → after the edge count_o=0, discard = outstanding−1, no stale instruction emerges.
- gnt held low 3 cycles with pc_valid_i=1 → imem_req_o=1 and pc_ready_o=0 throughout; accepted on the first gnt=1; address 0x1003 issued as 0x1000.
- Assert rst=0 asynchronously mid-stream with count=3 → outputs cleared without waiting for a clock edge: instr_valid_o=0, instr_o=0x00000013.
